// File: rtl/multi_port_cacheline_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_port_cacheline_adapter                                               |
// | Round-robin line-fill / write-back adapter: N cache clients, one burst mem.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multi_port_cacheline_adapter #(
  parameter int N_PORTS   = 2,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [31:0]                  bmem_addr,
  output logic                         bmem_read,
  output logic                         bmem_write,
  output logic [BEAT_BITS-1:0]         bmem_wdata,
  input  logic                         bmem_ready,
  input  logic [31:0]                  bmem_raddr,
  input  logic [BEAT_BITS-1:0]         bmem_rdata,
  input  logic                         bmem_rvalid,
  input  logic [N_PORTS*32-1:0]        port_addr,
  input  logic [N_PORTS-1:0]           port_read,
  input  logic [N_PORTS-1:0]           port_write,
  input  logic [N_PORTS*LINE_BITS-1:0] port_wdata,
  output logic [N_PORTS*LINE_BITS-1:0] port_rdata,
  output logic [N_PORTS-1:0]           port_resp,
  output logic                         orphan
);

  localparam int c_beats = LINE_BITS / BEAT_BITS;
  localparam int c_cnt_w = $clog2(c_beats);
  localparam int c_off_w = $clog2(LINE_BITS / 8);
  localparam int c_idx_w = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [31:0]        c_align_mask = ~((32'd1 << c_off_w) - 32'd1);
  localparam logic [c_cnt_w-1:0] c_last_beat  = c_cnt_w'(c_beats - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_FILL, S_WBURST, S_DONE
  } state_t;

  state_t               r_state   [N_PORTS];
  state_t               w_state_nx[N_PORTS];
  logic [31:0]          r_addr    [N_PORTS];
  logic [LINE_BITS-1:0] r_line    [N_PORTS];
  logic [N_PORTS-1:0]   r_is_wr;
  logic [c_idx_w-1:0]   r_rr;
  logic [c_cnt_w-1:0]   r_wcnt;
  logic [c_cnt_w-1:0]   r_rcnt;

  logic                 w_locked;
  logic [c_idx_w-1:0]   w_lock_idx;
  logic                 w_gnt_vld;
  logic [c_idx_w-1:0]   w_gnt_idx;
  logic [c_idx_w-1:0]   w_bus_idx;
  logic [31:0]          w_raddr_al;
  logic                 w_beat0;
  logic                 w_match_vld;
  logic [c_idx_w-1:0]   w_match_idx;

  // A port in WBURST owns the bus; otherwise the first ISSUE port from r_rr wins.
  always_comb begin
    w_locked   = 1'b0;
    w_lock_idx = '0;
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_state[i] == S_WBURST) begin
        w_locked   = 1'b1;
        w_lock_idx = c_idx_w'(i);
      end
    end
    if (!w_locked) begin
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        if (r_state[c_idx_w'((int'(r_rr) + k) % N_PORTS)] == S_ISSUE) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = c_idx_w'((int'(r_rr) + k) % N_PORTS);
        end
      end
    end
  end

  always_comb begin
    w_bus_idx  = w_locked ? w_lock_idx : w_gnt_idx;
    bmem_addr  = r_addr[w_bus_idx];
    bmem_read  = w_gnt_vld && !r_is_wr[w_gnt_idx];
    bmem_write = w_locked || (w_gnt_vld && r_is_wr[w_gnt_idx]);
    bmem_wdata = r_line[w_bus_idx][int'(r_wcnt)*BEAT_BITS +: BEAT_BITS];
  end

  // Beat 0 of a burst picks the lowest-index waiter with the same line address.
  always_comb begin
    w_raddr_al  = bmem_raddr & c_align_mask;
    w_beat0     = bmem_rvalid && (r_rcnt == '0);
    w_match_vld = 1'b0;
    w_match_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (r_state[i] == S_WAIT && r_addr[i] == w_raddr_al) begin
        w_match_vld = 1'b1;
        w_match_idx = c_idx_w'(i);
      end
    end
    orphan = w_beat0 && !w_match_vld;
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      w_state_nx[i] = r_state[i];
      case (r_state[i])
        S_IDLE:   if (port_read[i] || port_write[i]) w_state_nx[i] = S_ISSUE;
        S_ISSUE:  if (w_gnt_vld && w_gnt_idx == c_idx_w'(i)) begin
                    if (r_is_wr[i])      w_state_nx[i] = S_WBURST;
                    else if (bmem_ready) w_state_nx[i] = S_WAIT;
                  end
        S_WAIT:   if (w_beat0 && w_match_vld && w_match_idx == c_idx_w'(i))
                    w_state_nx[i] = S_FILL;
        S_FILL:   if (bmem_rvalid && r_rcnt == c_last_beat) w_state_nx[i] = S_DONE;
        S_WBURST: if (bmem_ready && r_wcnt == c_last_beat) w_state_nx[i] = S_DONE;
        S_DONE:   w_state_nx[i] = S_IDLE;
        default:  w_state_nx[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_PORTS; i++) r_state[i] <= S_IDLE;
      r_rr   <= '0;
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) r_state[i] <= w_state_nx[i];
      if (w_gnt_vld && (r_is_wr[w_gnt_idx] || bmem_ready))
        r_rr <= c_idx_w'((int'(w_gnt_idx) + 1) % N_PORTS);
      // Both counters wrap to zero on their last beat since BEATS is a power of two.
      if (bmem_write && bmem_ready) r_wcnt <= r_wcnt + 1'b1;
      if (bmem_rvalid)              r_rcnt <= r_rcnt + 1'b1;
    end
  end

  // The line register holds write-back data for writes and collects fill beats for reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_state[i] == S_IDLE && (port_read[i] || port_write[i])) begin
        r_addr[i]  <= port_addr[i*32 +: 32] & c_align_mask;
        r_is_wr[i] <= port_write[i];
        r_line[i]  <= port_wdata[i*LINE_BITS +: LINE_BITS];
      end else if (w_beat0 && w_match_vld && w_match_idx == c_idx_w'(i)) begin
        r_line[i][BEAT_BITS-1:0] <= bmem_rdata;
      end else if (r_state[i] == S_FILL && bmem_rvalid) begin
        r_line[i][int'(r_rcnt)*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
      end
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign port_rdata[gi*LINE_BITS +: LINE_BITS] = r_line[gi];
    assign port_resp[gi]                         = (r_state[gi] == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_port_cacheline_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multi_port_cacheline_adapter                                            |
// | Directed stimulus with queue-based scoreboard for the cacheline adapter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multi_port_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b1;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;
  logic [63:0]  port_addr = '0;
  logic [1:0]   port_read = '0, port_write = '0;
  logic [511:0] port_wdata = '0;
  logic [511:0] port_rdata;
  logic [1:0]   port_resp;
  logic         orphan;

  multi_port_cacheline_adapter #(.N_PORTS(2), .LINE_BITS(256), .BEAT_BITS(64)) dut (
    .clk(clk), .rst(rst),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
    .port_addr(port_addr), .port_read(port_read), .port_write(port_write),
    .port_wdata(port_wdata), .port_rdata(port_rdata), .port_resp(port_resp),
    .orphan(orphan)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit tog = 1'b0;
  always @(posedge clk) begin
    #1;
    if (tog) bmem_ready = ~bmem_ready;
    else     bmem_ready = 1'b1;
  end

  int total = 0;
  int bad   = 0;

  logic [95:0]  wq[$];   // {addr, beat}
  logic [31:0]  aq[$];   // read request addresses in issue order
  logic [256:0] rq0[$], rq1[$];  // {check_data, line}
  int           wbeat_cyc[$], rd_cyc[$];
  int           resp_cyc[2];
  int           orphan_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an unexpected event expected none", name);
  endtask

  task automatic pop_resp(input int p);
    logic [256:0] e;
    if (p == 0 ? rq0.size() == 0 : rq1.size() == 0) begin
      extra($sformatf("resp_extra_p%0d", p));
    end else begin
      e = (p == 0) ? rq0.pop_front() : rq1.pop_front();
      if (e[256]) check($sformatf("rdata_p%0d", p), port_rdata[p*256 +: 256], e[255:0]);
    end
  endtask

  // Monitor: every bus event and completion is compared against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (bmem_write && bmem_ready) begin
        logic [95:0] e;
        wbeat_cyc.push_back(cyc);
        if (wq.size() == 0) extra("wbeat_extra");
        else begin
          e = wq.pop_front();
          check("wbeat_addr", bmem_addr, e[95:64]);
          check("wbeat_data", bmem_wdata, e[63:0]);
        end
      end
      if (bmem_read && bmem_ready) begin
        rd_cyc.push_back(cyc);
        if (aq.size() == 0) extra("rd_extra");
        else check("rd_addr", bmem_addr, aq.pop_front());
      end
      for (int p = 0; p < 2; p++) begin
        if (port_resp[p]) begin
          resp_cyc[p] = cyc;
          pop_resp(p);
        end
      end
      if (orphan) orphan_cnt++;
    end
  end

  function automatic logic [255:0] mkline(input logic [63:0] base);
    return {base + 64'd3, base + 64'd2, base + 64'd1, base};
  endfunction

  task automatic do_req(input int p, input bit wr, input logic [31:0] a, input logic [255:0] line);
    int n;
    port_addr[p*32 +: 32]    = a;
    port_wdata[p*256 +: 256] = line;
    if (wr) port_write[p] = 1'b1;
    else    port_read[p]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!port_resp[p] && n < 300);
    if (!port_resp[p]) begin
      total++;
      bad++;
      $display("FAIL req_timeout_p%0d: got no resp expected resp within 300 cycles", p);
    end
    port_write[p] = 1'b0;
    port_read[p]  = 1'b0;
    #1;
  endtask

  task automatic burst(input logic [31:0] a, input logic [255:0] line);
    for (int b = 0; b < 4; b++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = a;
      bmem_rdata  = line[b*64 +: 64];
      @(posedge clk);
      #1;
    end
    bmem_rvalid = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [255:0] line);
    for (int b = 0; b < 4; b++) wq.push_back({a, line[b*64 +: 64]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    int t, n0, r0, o0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bmem_read", bmem_read, 0);
    check("rst_bmem_write", bmem_write, 0);
    check("rst_port_resp", port_resp, 0);
    check("rst_orphan", orphan, 0);
    rst = 1'b1;

    // 1: port1 write-back with ready held high.
    @(posedge clk); #1;
    t = cyc; n0 = wbeat_cyc.size();
    push_wr(32'h1000, {64'd4, 64'd3, 64'd2, 64'd1});
    rq1.push_back({1'b0, 256'h0});
    do_req(1, 1'b1, 32'h1000, {64'd4, 64'd3, 64'd2, 64'd1});
    check("t1_nbeats", wbeat_cyc.size() - n0, 4);
    check("t1_first_beat_cyc", wbeat_cyc[n0], t + 1);
    check("t1_last_beat_cyc", wbeat_cyc[n0+3], t + 4);
    check("t1_resp_cyc", resp_cyc[1], t + 5);

    // 2: port1 write with ready toggling.
    @(posedge clk); #1;
    tog = 1'b1;
    n0 = wbeat_cyc.size();
    push_wr(32'h6000, mkline(64'hD0));
    rq1.push_back({1'b0, 256'h0});
    do_req(1, 1'b1, 32'h6000, mkline(64'hD0));
    tog = 1'b0;
    check("t2_nbeats", wbeat_cyc.size() - n0, 4);

    // 3: simultaneous reads, memory answers the later-issued one first.
    @(posedge clk); #1;
    t = cyc; r0 = rd_cyc.size();
    aq.push_back(32'h2000);
    aq.push_back(32'h3000);
    rq0.push_back({1'b1, mkline(64'h2000_0000)});
    rq1.push_back({1'b1, mkline(64'h3000_0000)});
    fork
      do_req(0, 1'b0, 32'h2000, '0);
      do_req(1, 1'b0, 32'h3000, '0);
      begin
        repeat (4) @(posedge clk);
        #1;
        burst(32'h3000, mkline(64'h3000_0000));
        burst(32'h2000, mkline(64'h2000_0000));
      end
    join
    check("t3_p0_issue_cyc", rd_cyc[r0], t + 1);
    check("t3_p1_issue_cyc", rd_cyc[r0+1], t + 2);
    check("t3_p1_before_p0", resp_cyc[1] < resp_cyc[0], 1);

    // 4: read return overlapping a write burst.
    @(posedge clk); #1;
    aq.push_back(32'h5000);
    rq1.push_back({1'b1, mkline(64'h5000_0000)});
    push_wr(32'h4000, mkline(64'h4000_00A0));
    rq0.push_back({1'b0, 256'h0});
    n0 = wbeat_cyc.size();
    fork
      do_req(1, 1'b0, 32'h5000, '0);
      begin
        repeat (3) @(posedge clk);
        #1;
        fork
          do_req(0, 1'b1, 32'h4000, mkline(64'h4000_00A0));
          burst(32'h5000, mkline(64'h5000_0000));
        join
      end
    join
    check("t4_beats_back_to_back", wbeat_cyc[n0+3] - wbeat_cyc[n0], 3);

    // 5: burst nobody waits for, then a normal fill.
    @(posedge clk); #1;
    o0 = orphan_cnt;
    burst(32'h9000, mkline(64'hBAD0));
    aq.push_back(32'hA000);
    rq0.push_back({1'b1, mkline(64'hA000_0000)});
    fork
      do_req(0, 1'b0, 32'hA000, '0);
      begin
        repeat (3) @(posedge clk);
        #1;
        burst(32'hA000, mkline(64'hA000_0000));
      end
    join
    check("t5_orphan_once", orphan_cnt - o0, 1);

    // 6: reset in the middle of a fill, then a clean read.
    @(posedge clk); #1;
    aq.push_back(32'hB000);
    port_addr[31:0] = 32'hB000;
    port_read[0]    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'hB000;
      bmem_rdata  = 64'hB0 + 64'(b);
      @(posedge clk);
      #1;
    end
    bmem_rvalid  = 1'b0;
    port_read[0] = 1'b0;
    rst          = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_bmem_read", bmem_read, 0);
    check("t6_bmem_write", bmem_write, 0);
    check("t6_port_resp", port_resp, 0);
    check("t6_orphan", orphan, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    aq.push_back(32'hC000);
    rq0.push_back({1'b1, mkline(64'hC000_0000)});
    fork
      do_req(0, 1'b0, 32'hC000, '0);
      begin
        repeat (3) @(posedge clk);
        #1;
        burst(32'hC000, mkline(64'hC000_0000));
      end
    join

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    check("end_wq_empty", wq.size(), 0);
    check("end_aq_empty", aq.size(), 0);
    check("end_rq0_empty", rq0.size(), 0);
    check("end_rq1_empty", rq1.size(), 0);
    check("end_orphan_total", orphan_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
